mem_arbiter: RTL

- Sequences and shares the single unified main memory between the I-cache miss handler and the D-cache miss/store path.
- Main memory is pipelined with a fixed read latency.
- Fills issue one word address per cycle and stream the returned words back to the owning cache with a word index.
- Sits between both caches and the memory macro, replacing the two single-cycle memories in the datapath.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/fill_counter.sv | 35 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared state encoding, defaults and block helpers for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        WRITE  = 2'b01,
        FILL_D = 2'b10,
        FILL_I = 2'b11
    } arb_state_e;

    localparam int          DEF_WORDS_PER_BLOCK = 8;
    localparam int          DEF_MEM_LATENCY     = 4;
    localparam logic [15:0] BLOCK_MASK          = 16'hFFF0;

    function automatic logic [15:0] block_base(input logic [15:0] addr);
        return addr & BLOCK_MASK;
    endfunction

endpackage

// File: rtl/fill_counter.sv
// rtl/fill_counter.sv - issue/receive word counters for one block fill
module fill_counter #(
    parameter  int WORDS_PER_BLOCK = 8,
    localparam int IDX_W           = $clog2(WORDS_PER_BLOCK),
    localparam int CNT_W           = IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             issue_inc,
    input  logic             recv_inc,
    output logic [CNT_W-1:0] issue_cnt,
    output logic [IDX_W-1:0] recv_cnt,
    output logic             issue_active,
    output logic             last_word
);

    // clear wins over increment so the final beat leaves both counters at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else if (clear) begin
            issue_cnt <= '0;
            recv_cnt  <= '0;
        end else begin
            if (issue_inc) issue_cnt <= issue_cnt + CNT_W'(1);
            if (recv_inc)  recv_cnt  <= recv_cnt + IDX_W'(1);
        end
    end

    assign issue_active = issue_cnt < CNT_W'(WORDS_PER_BLOCK);
    assign last_word    = recv_cnt == IDX_W'(WORDS_PER_BLOCK - 1);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one pipelined main memory between I-cache fills and D-cache fills/stores
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int ADDR_W          = 16,
    parameter  int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
    parameter  int MEM_LATENCY     = DEF_MEM_LATENCY,
    localparam int IDX_W           = $clog2(WORDS_PER_BLOCK),
    localparam int CNT_W           = IDX_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              icache_miss,
    input  logic [ADDR_W-1:0] icache_addr,
    input  logic              dcache_miss,
    input  logic [ADDR_W-1:0] dcache_addr,
    input  logic              dcache_wr_req,
    input  logic [ADDR_W-1:0] dcache_wdata,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ADDR_W-1:0] mem_wdata,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic              mem_data_valid,
    output logic [ADDR_W-1:0] fill_data,
    output logic              icache_fill_valid,
    output logic              dcache_fill_valid,
    output logic [IDX_W-1:0]  fill_idx,
    output logic              icache_done,
    output logic              dcache_done,
    output logic              dcache_wr_ack,
    output logic              busy
);

    if (WORDS_PER_BLOCK < 2 || (WORDS_PER_BLOCK & (WORDS_PER_BLOCK - 1)) != 0) begin : g_bad_wpb
        $error("mem_arbiter: WORDS_PER_BLOCK must be a power of 2");
    end
    if (MEM_LATENCY < 1) begin : g_bad_lat
        $error("mem_arbiter: MEM_LATENCY must be at least 1");
    end

    arb_state_e        state, next_state;
    logic [ADDR_W-1:0] base, base_src;
    logic              latch_base;
    logic              cnt_clear, issue_inc, recv_inc;
    logic [CNT_W-1:0]  issue_cnt;
    logic [IDX_W-1:0]  recv_cnt;
    logic              issue_active, last_word;

    fill_counter #(.WORDS_PER_BLOCK(WORDS_PER_BLOCK)) u_fill_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (cnt_clear),
        .issue_inc    (issue_inc),
        .recv_inc     (recv_inc),
        .issue_cnt    (issue_cnt),
        .recv_cnt     (recv_cnt),
        .issue_active (issue_active),
        .last_word    (last_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            base  <= '0;
        end else begin
            state <= next_state;
            if (latch_base) base <= block_base(base_src);
        end
    end

    assign fill_data = mem_rdata;
    assign busy      = state != IDLE;

    always_comb begin
        next_state        = state;
        mem_en            = 1'b0;
        mem_wr            = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;
        icache_fill_valid = 1'b0;
        dcache_fill_valid = 1'b0;
        fill_idx          = '0;
        icache_done       = 1'b0;
        dcache_done       = 1'b0;
        dcache_wr_ack     = 1'b0;
        cnt_clear         = 1'b0;
        issue_inc         = 1'b0;
        recv_inc          = 1'b0;
        latch_base        = 1'b0;
        base_src          = icache_addr;
        case (state)
            IDLE: begin
                cnt_clear = 1'b1;
                if (dcache_wr_req) begin
                    next_state = WRITE;
                end else if (dcache_miss) begin
                    next_state = FILL_D;
                    latch_base = 1'b1;
                    base_src   = dcache_addr;
                end else if (icache_miss) begin
                    next_state = FILL_I;
                    latch_base = 1'b1;
                end
            end
            WRITE: begin
                mem_en        = 1'b1;
                mem_wr        = 1'b1;
                mem_addr      = dcache_addr;
                mem_wdata     = dcache_wdata;
                dcache_wr_ack = 1'b1;
                next_state    = IDLE;
            end
            FILL_D, FILL_I: begin
                // issue and receive overlap; data returns while later addresses still go out
                mem_en    = issue_active;
                issue_inc = issue_active;
                if (issue_active) mem_addr = base + ADDR_W'({issue_cnt, 1'b0});
                if (mem_data_valid) begin
                    recv_inc          = 1'b1;
                    fill_idx          = recv_cnt;
                    dcache_fill_valid = (state == FILL_D);
                    icache_fill_valid = (state == FILL_I);
                    if (last_word) begin
                        dcache_done = (state == FILL_D);
                        icache_done = (state == FILL_I);
                        cnt_clear   = 1'b1;
                        next_state  = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule
